uart_rx_sequencer: RTL and testbench

UART receive-side frame sequencer. Double-synchronises the asynchronous `rx_i` line and instantiates the negative-edge `edge_detector` to catch start bits. It sequences oversampled mid-bit sampling through start, data, optional parity and stop bits, and delivers a parallel byte with error flags to the RX FIFO. It sits between the baud-rate generator, which supplies `ov_tick_i`, and the RX buffer.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_sequencer_if.sv | 32 +++
 rtl/edge_detector.sv | 34 +++
 rtl/uart_rx_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  uart_pkg
//  Shared UART receive types and helpers.
//  Revision: 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        DW_5 = 2'b00,
        DW_6 = 2'b01,
        DW_7 = 2'b10,
        DW_8 = 2'b11
    } data_width_t;

    // Tick count at which the start bit is centred.
    function automatic int half_bit(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic logic [2:0] last_bit_idx(input data_width_t w);
        return 3'd4 + {1'b0, w};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  uart_rx_sequencer_if
//  Received-word bus from the frame sequencer towards the RX FIFO.
//  Revision: 1.0
// ============================================================================
interface uart_rx_sequencer_if #(
    parameter int DATA_MAX = 8
);
    logic [DATA_MAX-1:0] data_o;
    logic                data_valid_o;
    logic                parity_err_o;
    logic                frame_err_o;
    logic                busy_o;

    modport master (
        output data_o,
        output data_valid_o,
        output parity_err_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        input data_o,
        input data_valid_o,
        input parity_err_o,
        input frame_err_o,
        input busy_o
    );
endinterface
`default_nettype wire

// File: rtl/edge_detector.sv
`default_nettype none
// ============================================================================
//  edge_detector
//  One-clock pulse on a selected edge of a synchronous input (EDGE: 1 rise, 0 fall).
//  Revision: 1.0
// ============================================================================
module edge_detector #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic pulse_o
);
    logic r_prev;

    // Reset to the idle level so no edge is reported out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_prev <= ~EDGE;
        end else begin
            r_prev <= sig_i;
        end
    end

    generate
        if (EDGE) begin : g_rise
            assign pulse_o = sig_i & ~r_prev;
        end else begin : g_fall
            assign pulse_o = r_prev & ~sig_i;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  uart_rx_sequencer
//  UART receive frame sequencer: oversampled start/data/parity/stop sampling.
//  Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around each sample point.
//  Revision: 1.0
// ============================================================================
module uart_rx_sequencer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_MAX   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rx_i,
    input  logic                      ov_tick_i,
    input  logic                      enable_i,
    input  logic [1:0]                data_width_i,
    input  logic                      parity_en_i,
    input  logic                      parity_odd_i,
    input  logic                      stop_bits_i,
    uart_rx_sequencer_if.master       rx_if
);
    localparam int HALF_BIT = half_bit(OVERSAMPLE);
    localparam int CW       = $clog2(OVERSAMPLE);

    localparam logic [2:0] ST_IDLE   = RX_IDLE;
    localparam logic [2:0] ST_START  = RX_START;
    localparam logic [2:0] ST_DATA   = RX_DATA;
    localparam logic [2:0] ST_PARITY = RX_PARITY;
    localparam logic [2:0] ST_STOP   = RX_STOP;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] c_start_pt = CW'(HALF_BIT + 1);
`else
    localparam logic [CW-1:0] c_start_pt = CW'(HALF_BIT);
`endif
    localparam logic [CW-1:0] c_bit_pt = CW'(OVERSAMPLE - 1);

    logic                r_sync_1;
    logic                r_sync_2;
    logic                w_fall;
    logic                w_bit;
    logic                w_sample;
    logic [CW-1:0]       w_pt;
    logic [2:0]          w_last_idx;

    logic [2:0]          r_state;
    logic [CW-1:0]       r_tick_cnt;
    logic [2:0]          r_bit_cnt;
    logic                r_stop_cnt;
    data_width_t         r_width;
    logic                r_par_en;
    logic                r_par_odd;
    logic                r_two_stop;
    logic [DATA_MAX-1:0] r_shift;
    logic                r_par_acc;
    logic                r_ferr_acc;

    logic [DATA_MAX-1:0] r_data;
    logic                r_valid;
    logic                r_perr;
    logic                r_ferr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= rx_i;
            r_sync_2 <= r_sync_1;
        end
    end

    edge_detector #(
        .EDGE (1'b0)
    ) u_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .sig_i   (r_sync_2),
        .pulse_o (w_fall)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // r_hist holds the line at ticks C-1 and C; the current line is tick C+1.
    logic [1:0] r_hist;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hist <= 2'b11;
        end else if (ov_tick_i) begin
            r_hist <= {r_hist[0], r_sync_2};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync_2) | (r_hist[0] & r_sync_2);
`else
    assign w_bit = r_sync_2;
`endif

    assign w_pt       = (r_state == ST_START) ? c_start_pt : c_bit_pt;
    assign w_sample   = ov_tick_i && (r_tick_cnt == w_pt);
    assign w_last_idx = last_bit_idx(r_width);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
            r_width    <= DW_8;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if ((r_state != ST_IDLE) && !enable_i) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                if (w_fall && enable_i) begin
                    r_width    <= data_width_t'(data_width_i);
                    r_par_en   <= parity_en_i;
                    r_par_odd  <= parity_odd_i;
                    r_two_stop <= stop_bits_i;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= 3'd0;
                    r_stop_cnt <= 1'b0;
                    r_shift    <= '0;
                    r_par_acc  <= 1'b0;
                    r_ferr_acc <= 1'b0;
                    r_state    <= ST_START;
                end
            end else if (ov_tick_i) begin
                if (!w_sample) begin
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end else begin
                    r_tick_cnt <= '0;
                    case (r_state)
                        ST_START: begin
                            r_state <= w_bit ? ST_IDLE : ST_DATA;
                        end
                        ST_DATA: begin
                            r_shift[r_bit_cnt] <= w_bit;
                            r_par_acc          <= r_par_acc ^ w_bit;
                            r_bit_cnt          <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == w_last_idx) begin
                                r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            end
                        end
                        ST_PARITY: begin
                            r_par_acc <= r_par_acc ^ w_bit;
                            r_state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (r_two_stop && !r_stop_cnt) begin
                                r_stop_cnt <= 1'b1;
                                r_ferr_acc <= r_ferr_acc | ~w_bit;
                            end else begin
                                r_state <= ST_IDLE;
                                r_valid <= 1'b1;
                                r_data  <= r_shift;
                                r_perr  <= r_par_en & (r_par_acc != r_par_odd);
                                r_ferr  <= r_ferr_acc | ~w_bit;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign rx_if.data_o       = r_data;
    assign rx_if.data_valid_o = r_valid;
    assign rx_if.parity_err_o = r_perr;
    assign rx_if.frame_err_o  = r_ferr;
    assign rx_if.busy_o       = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_uart_rx_sequencer
//  Directed frames against a frame-level model of expected words and timing.
//  Revision: 1.0
// ============================================================================
module tb_uart_rx_sequencer;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE = 1;
`else
    localparam int VOTE = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       ov_tick = 1'b1;
    logic       enable  = 1'b0;
    logic [1:0] dw      = 2'b11;
    logic       pen     = 1'b0;
    logic       podd    = 1'b0;
    logic       sb      = 1'b0;

    uart_rx_sequencer_if #(.DATA_MAX(8)) rx_if ();

    uart_rx_sequencer #(
        .OVERSAMPLE (16),
        .DATA_MAX   (8)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .rx_i         (rx),
        .ov_tick_i    (ov_tick),
        .enable_i     (enable),
        .data_width_i (dw),
        .parity_en_i  (pen),
        .parity_odd_i (podd),
        .stop_bits_i  (sb),
        .rx_if        (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   last_dv_cyc = -1;
    int   last_k      = 0;
    bit   mon_en      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: data_valid_o must pulse exactly at the model's cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && cyc == q[0].cyc) begin
                check("dv_expected", rx_if.data_valid_o, 1);
                check("data", rx_if.data_o, q[0].data);
                check("parity_err", rx_if.parity_err_o, q[0].perr);
                check("frame_err", rx_if.frame_err_o, q[0].ferr);
                check("busy_at_dv", rx_if.busy_o, 0);
                void'(q.pop_front());
            end else begin
                check("dv_unexpected", rx_if.data_valid_o, 0);
            end
            if (rx_if.data_valid_o) last_dv_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bit period of 16 clocks; optional one-clock low spike at its centre.
    task automatic drive_bit(input logic b, input bit spike);
        for (int o = 0; o < 16; o++) begin
            rx = (spike && o == 8) ? 1'b0 : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int nbits, input bit p_en, input bit p_odd, input bit two_stop,
                              input logic [7:0] d, input bit p_flip, input bit stop2,
                              input int spike_bit);
        logic [7:0] mask;
        logic [7:0] seen;
        logic       pbit;
        exp_t       e;
        int         k;
        dw   = 2'(nbits - 5);
        pen  = p_en;
        podd = p_odd;
        sb   = two_stop;
        mask = 8'hFF >> (8 - nbits);
        seen = d & mask;
        pbit = (^seen) ^ p_odd ^ p_flip;
        if (spike_bit >= 0 && VOTE == 0) seen[spike_bit] = 1'b0;
        k      = cyc + 1;
        last_k = k;
        e.cyc  = k + 10 + 16 * (nbits + int'(p_en) + 1 + int'(two_stop)) + VOTE;
        e.data = seen;
        e.perr = p_en && (((^seen) ^ pbit) != p_odd);
        e.ferr = two_stop && !stop2;
        q.push_back(e);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(d[i], i == spike_bit);
        if (p_en) drive_bit(pbit, 1'b0);
        drive_bit(1'b1, 1'b0);
        if (two_stop) drive_bit(stop2, 1'b0);
        rx = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         busy_cnt;
        logic [7:0] ab;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_data", rx_if.data_o, 0);
        check("reset_dv", rx_if.data_valid_o, 0);
        check("reset_perr", rx_if.parity_err_o, 0);
        check("reset_ferr", rx_if.frame_err_o, 0);
        check("reset_busy", rx_if.busy_o, 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        mon_en = 1'b1;
        idle(5);

        // 8N1 0xA5
        send_frame(8, 0, 0, 0, 8'hA5, 0, 1, -1);
        idle(20);
        check("8n1_latency_from_pulse", last_dv_cyc - (last_k + 1), 153 + VOTE);
        check("8n1_data", rx_if.data_o, 8'hA5);
        check("8n1_perr", rx_if.parity_err_o, 0);

        // 7E1 0x41, wrong parity bit
        send_frame(7, 1, 0, 0, 8'h41, 1, 1, -1);
        idle(20);
        check("7e1_data", rx_if.data_o, 8'h41);
        check("7e1_perr", rx_if.parity_err_o, 1);
        check("7e1_ferr", rx_if.frame_err_o, 0);

        // 4-clock glitch: false start
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            rx = (c < 4) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rx_if.busy_o) busy_cnt++;
            @(posedge clk);
            #1;
        end
        check("glitch_busy_cycles", busy_cnt, 8 + VOTE);
        check("glitch_data_held", rx_if.data_o, 8'h41);

        // 5N2 0x1F, second stop bit low
        send_frame(5, 0, 0, 1, 8'h1F, 0, 0, -1);
        idle(20);
        check("5n2_data", rx_if.data_o, 8'h1F);
        check("5n2_ferr", rx_if.frame_err_o, 1);
        check("5n2_perr", rx_if.parity_err_o, 0);

        // Abort mid-DATA, then a clean 8N1 0x3C
        dw = 2'b11; pen = 1'b0; sb = 1'b0;
        ab = 8'h96;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(ab[i], 1'b0);
        check("abort_busy_before", rx_if.busy_o, 1);
        enable = 1'b0;
        for (int i = 3; i < 8; i++) drive_bit(ab[i], 1'b0);
        drive_bit(1'b1, 1'b0);
        check("abort_busy_after", rx_if.busy_o, 0);
        enable = 1'b1;
        idle(10);
        check("abort_data_unchanged", rx_if.data_o, 8'h1F);
        send_frame(8, 0, 0, 0, 8'h3C, 0, 1, -1);
        idle(20);
        check("after_abort_data", rx_if.data_o, 8'h3C);

        // Back-to-back frames, odd parity on the second
        send_frame(8, 0, 0, 0, 8'h5A, 0, 1, -1);
        send_frame(6, 1, 1, 0, 8'h2B, 0, 1, -1);
        idle(20);
        check("b2b_data", rx_if.data_o, 8'h2B);
        check("b2b_perr", rx_if.parity_err_o, 0);

        // Centre spike on a 1 data bit
        send_frame(8, 0, 0, 0, 8'hFF, 0, 1, 3);
        idle(20);
        check("spike_data", rx_if.data_o, (VOTE != 0) ? 8'hFF : 8'hF7);

        // Reset mid-frame
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        check("midframe_busy", rx_if.busy_o, 1);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("rst_busy", rx_if.busy_o, 0);
        check("rst_data", rx_if.data_o, 0);
        check("rst_dv", rx_if.data_valid_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(30);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
